// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the register-file write port between WB and a multi-cycle unit,
// tracks in-flight MCU destinations; RFARB_STARVE_GUARD_EN enables the MCU starvation guard.
module regfile_wport_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
`ifdef RFARB_STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT = 4
`endif
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_wd,
    input  logic            i_mcu_valid,
    input  logic [AW-1:0]   i_mcu_rd,
    input  logic [XLEN-1:0] i_mcu_wd,
    output logic            o_mcu_ready,
    input  logic            i_issue_valid,
    input  logic [AW-1:0]   i_issue_rd,
    input  logic [AW-1:0]   i_rs1,
    input  logic [AW-1:0]   i_rs2,
    input  logic [AW-1:0]   i_rd,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    output logic            o_rd_busy,
    output logic            o_wb_stall_req,
    output logic            o_we3,
    output logic [AW-1:0]   o_a3,
    output logic [XLEN-1:0] o_wd3,
    output logic            o_sb_err
);
    logic            w_mcu_grant;
    logic            w_err;
    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_nxt;
    logic            r_sb_err;

    assign w_mcu_grant = !i_wb_we && i_mcu_valid;
    assign o_mcu_ready = w_mcu_grant;

    // Writes to x0 still complete the handshake but never reach the register file.
    always_comb begin
        o_we3 = i_wb_we ? (i_wb_rd != '0) : (w_mcu_grant && (i_mcu_rd != '0));
        o_a3  = i_wb_we ? i_wb_rd : (w_mcu_grant ? i_mcu_rd : '0);
        o_wd3 = i_wb_we ? i_wb_wd : (w_mcu_grant ? i_mcu_wd : '0);
    end

    // Clear first, then set, so a same-cycle reissue keeps the register reserved.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_mcu_grant) w_pend_nxt[i_mcu_rd] = 1'b0;
        if (i_issue_valid) w_pend_nxt[i_issue_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_comb begin
        w_err = (i_issue_valid && r_pend[i_issue_rd])
             || (w_mcu_grant && (i_mcu_rd != '0) && !r_pend[i_mcu_rd]
                 && !(i_issue_valid && (i_issue_rd == i_mcu_rd)))
             || (i_wb_we && (i_wb_rd != '0) && r_pend[i_wb_rd]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend   <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_pend   <= w_pend_nxt;
            r_sb_err <= r_sb_err || w_err;
        end
    end

    assign o_rs1_busy = r_pend[i_rs1];
    assign o_rs2_busy = r_pend[i_rs2];
    assign o_rd_busy  = r_pend[i_rd];
    assign o_sb_err   = r_sb_err;

`ifdef RFARB_STARVE_GUARD_EN
    localparam logic [3:0] SAT = 4'(MAX_WAIT);
    logic [3:0] r_wait;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_wait <= '0;
        else r_wait <= (!i_mcu_valid || w_mcu_grant) ? '0 : ((r_wait == SAT) ? r_wait : r_wait + 4'd1);
    end

    assign o_wb_stall_req = (r_wait == SAT);
`else
    assign o_wb_stall_req = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wport_arbiter;
    localparam int MW = 4;
`ifdef RFARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic wb_we = 1'b0, mcu_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0] wb_rd = '0, mcu_rd = '0, issue_rd = '0, rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] wb_wd = '0, mcu_wd = '0;
    logic mcu_ready, rs1_busy, rs2_busy, rd_busy, wb_stall_req, we3, sb_err;
    logic [4:0] a3;
    logic [31:0] wd3;

    int errors = 0, checks = 0;
    bit [31:0] m_pend;
    bit m_err;
    int m_cnt;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    regfile_wport_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_wd(wb_wd),
        .i_mcu_valid(mcu_valid), .i_mcu_rd(mcu_rd), .i_mcu_wd(mcu_wd), .o_mcu_ready(mcu_ready),
        .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
        .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd),
        .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy), .o_rd_busy(rd_busy),
        .o_wb_stall_req(wb_stall_req),
        .o_we3(we3), .o_a3(a3), .o_wd3(wd3), .o_sb_err(sb_err)
    );

    function automatic bit mcu_wins();
        return !wb_we && mcu_valid;
    endfunction

    function automatic bit exp_we();
        if (wb_we) return wb_rd != 0;
        if (mcu_valid) return mcu_rd != 0;
        return 1'b0;
    endfunction

    function automatic logic [4:0] exp_a3();
        return wb_we ? wb_rd : (mcu_valid ? mcu_rd : 5'd0);
    endfunction

    function automatic logic [31:0] exp_wd();
        return wb_we ? wb_wd : (mcu_valid ? mcu_wd : 32'd0);
    endfunction

    function automatic bit exp_stall();
        return GUARD && (m_cnt == MW);
    endfunction

    task automatic model_clear();
        m_pend = '0;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic idle();
        wb_we = 0; mcu_valid = 0; issue_valid = 0;
        wb_rd = 0; mcu_rd = 0; issue_rd = 0; wb_wd = 0; mcu_wd = 0;
    endtask

    // Advance one clock: capture what the DUT presented to the register file, then step the model.
    task automatic tick();
        bit [31:0] np;
        @(negedge clk);
        if (we3) rf[a3] = wd3;
        @(posedge clk);
        np = m_pend;
        if (issue_valid && m_pend[issue_rd]) m_err = 1;
        if (mcu_wins() && mcu_rd != 0 && !m_pend[mcu_rd] && !(issue_valid && issue_rd == mcu_rd)) m_err = 1;
        if (wb_we && wb_rd != 0 && m_pend[wb_rd]) m_err = 1;
        if (mcu_wins()) np[mcu_rd] = 0;
        if (issue_valid && issue_rd != 0) np[issue_rd] = 1;
        m_pend = np;
        m_cnt = (!mcu_valid || mcu_wins()) ? 0 : ((m_cnt + 1 > MW) ? MW : m_cnt + 1);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_clear();
        #2;
        checks++;
        if ({rs1_busy, rs2_busy, rd_busy, sb_err, wb_stall_req, mcu_ready, we3} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=0", {rs1_busy, rs2_busy, rd_busy, sb_err, wb_stall_req, mcu_ready, we3});
        end
        checks++;
        if (a3 !== 5'd0 || wd3 !== 32'd0) begin
            errors++; $display("FAIL reset_port a3=%0d wd3=%h want 0/0", a3, wd3);
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_basic();
        issue_valid = 1; issue_rd = 5; rs1 = 5;
        #2;
        checks++;
        if (rs1_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_pre got=%b want=0", rs1_busy); end
        tick();
        issue_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (rs1_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_cyc%0d got=%b want=1", i, rs1_busy); end
            tick();
        end
        mcu_valid = 1; mcu_rd = 5; mcu_wd = 32'hDEAD;
        #2;
        checks++;
        if ({we3, mcu_ready} !== 2'b11 || a3 !== 5'd5 || wd3 !== 32'hDEAD) begin
            errors++; $display("FAIL basic_commit we3=%b rdy=%b a3=%0d wd3=%h want 1/1/5/dead", we3, mcu_ready, a3, wd3);
        end
        tick();
        mcu_valid = 0;
        #2;
        checks++;
        if (rs1_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_post got=%b want=0", rs1_busy); end
        checks++;
        if (rf[5] !== 32'hDEAD) begin errors++; $display("FAIL basic_rf got=%h want=dead", rf[5]); end
    endtask

    task automatic test_priority();
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        wb_we = 1; wb_rd = 3; wb_wd = 32'h11;
        mcu_valid = 1; mcu_rd = 7; mcu_wd = 32'h22;
        #2;
        checks++;
        if (we3 !== 1'b1 || a3 !== 5'd3 || wd3 !== 32'h11 || mcu_ready !== 1'b0) begin
            errors++; $display("FAIL prio_wb we3=%b a3=%0d wd3=%h rdy=%b want 1/3/11/0", we3, a3, wd3, mcu_ready);
        end
        tick();
        wb_we = 0;
        #2;
        checks++;
        if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'h22 || mcu_ready !== 1'b1) begin
            errors++; $display("FAIL prio_mcu we3=%b a3=%0d wd3=%h rdy=%b want 1/7/22/1", we3, a3, wd3, mcu_ready);
        end
        tick();
        idle();
        #2;
        checks++;
        if (sb_err !== 1'b0) begin errors++; $display("FAIL prio_err got=%b want=0", sb_err); end
    endtask

    task automatic test_starve();
        issue_valid = 1; issue_rd = 8;
        tick();
        issue_valid = 0;
        mcu_valid = 1; mcu_rd = 8; mcu_wd = 32'h88;
        wb_we = 1; wb_rd = 1;
        for (int i = 1; i <= 6; i++) begin
            wb_wd = $urandom;
            #2;
            checks++;
            if (wb_stall_req !== (GUARD && i >= MW + 1)) begin
                errors++; $display("FAIL starve_cyc%0d stall=%b want=%b", i, wb_stall_req, GUARD && i >= MW + 1);
            end
            tick();
        end
        wb_we = 0;
        #2;
        checks++;
        if (mcu_ready !== 1'b1 || a3 !== 5'd8) begin
            errors++; $display("FAIL starve_grant rdy=%b a3=%0d want 1/8", mcu_ready, a3);
        end
        tick();
        mcu_valid = 0;
        #2;
        checks++;
        if (wb_stall_req !== 1'b0) begin errors++; $display("FAIL starve_clear stall=%b want=0", wb_stall_req); end
        idle();
    endtask

    task automatic test_set_clear();
        issue_valid = 1; issue_rd = 9;
        mcu_valid = 1; mcu_rd = 9; mcu_wd = 32'h99;
        tick();
        idle();
        rs1 = 9;
        #2;
        checks++;
        if (rs1_busy !== 1'b1 || sb_err !== 1'b0) begin
            errors++; $display("FAIL setclr busy=%b err=%b want 1/0", rs1_busy, sb_err);
        end
        issue_valid = 1; issue_rd = 9;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (sb_err !== 1'b1) begin errors++; $display("FAIL setclr_sticky%0d err=%b want=1", i, sb_err); end
            tick();
        end
    endtask

    task automatic test_x0_and_async_reset();
        test_reset();
        mcu_valid = 1; mcu_rd = 0; mcu_wd = 32'h55;
        #2;
        checks++;
        if (mcu_ready !== 1'b1 || we3 !== 1'b0) begin
            errors++; $display("FAIL x0_commit rdy=%b we3=%b want 1/0", mcu_ready, we3);
        end
        tick();
        idle();
        issue_valid = 1; issue_rd = 5;
        tick();
        issue_rd = 9;
        tick();
        idle();
        rs1 = 5; rs2 = 9;
        #2;
        checks++;
        if ({rs1_busy, rs2_busy} !== 2'b11) begin
            errors++; $display("FAIL areset_pre busy=%b want=11", {rs1_busy, rs2_busy});
        end
        rst_n = 0;
        model_clear();
        #1;
        checks++;
        if ({rs1_busy, rs2_busy, sb_err} !== 3'b000) begin
            errors++; $display("FAIL areset_now busy/err=%b want=000", {rs1_busy, rs2_busy, sb_err});
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wb_we = ($urandom_range(0, 2) == 0);
            wb_rd = 5'($urandom_range(0, 7));
            wb_wd = $urandom;
            mcu_valid = ($urandom_range(0, 1) == 0);
            mcu_rd = 5'($urandom_range(0, 7));
            mcu_wd = $urandom;
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            if (n == 200) begin
                rst_n = 0;
                model_clear();
                #1;
                rst_n = 1;
            end
            #2;
            checks++;
            if (mcu_ready !== mcu_wins()) begin errors++; $display("FAIL rnd%0d ready=%b want=%b", n, mcu_ready, mcu_wins()); end
            checks++;
            if (we3 !== exp_we()) begin errors++; $display("FAIL rnd%0d we3=%b want=%b", n, we3, exp_we()); end
            checks++;
            if (exp_we() && (a3 !== exp_a3() || wd3 !== exp_wd())) begin
                errors++; $display("FAIL rnd%0d a3=%0d wd3=%h want %0d/%h", n, a3, wd3, exp_a3(), exp_wd());
            end
            checks++;
            if ({rs1_busy, rs2_busy, rd_busy} !== {m_pend[rs1], m_pend[rs2], m_pend[rd]}) begin
                errors++; $display("FAIL rnd%0d busy=%b want=%b", n, {rs1_busy, rs2_busy, rd_busy}, {m_pend[rs1], m_pend[rs2], m_pend[rd]});
            end
            checks++;
            if (wb_stall_req !== exp_stall()) begin errors++; $display("FAIL rnd%0d stall=%b want=%b", n, wb_stall_req, exp_stall()); end
            checks++;
            if (sb_err !== m_err) begin errors++; $display("FAIL rnd%0d sb_err=%b want=%b", n, sb_err, m_err); end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        #1;
        test_reset();
        test_basic();
        test_priority();
        test_starve();
        test_set_clear();
        test_x0_and_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
